cb_seq_ctrl: RTL

- Sequencing controller for the code-block segmentation datapath: padding mux, CRC24 engine, CRC output mux and the serial TB data FIFO.
- Accepts one segmentation descriptor per transport block from the block-size computation stage.
- Walks C code blocks bit by bit, inserting F filler zeros at the head of block 0 and a 24-bit CRC at the tail of every block when C>1.
- Drives all mux selects, CRC controls, FIFO reads and the per-bit framing flags.

---
 rtl/cb_seq_ctrl_pkg.sv | 29 ++
 rtl/cb_seq_ctrl_if.sv | 29 ++
 rtl/cb_len_calc.sv | 36 +++
 rtl/cb_seq_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/cb_seq_ctrl_pkg.sv
`default_nettype none
//==========================================================================
// cb_seq_ctrl_pkg : shared types and constants for the CB sequencer
// Rev 1.0
//==========================================================================
package cb_seq_ctrl_pkg;

  localparam int KW_DEF  = 13;
  localparam int CW_DEF  = 5;
  localparam int FW_DEF  = 6;
  localparam int CRC_LEN = 24;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_BSTART = 3'd2,
    S_FILL   = 3'd3,
    S_DATA   = 3'd4,
    S_CRCO   = 3'd5,
    S_FIN    = 3'd6
  } state_t;

  // The first c_minus blocks use K-, the rest K+.
  function automatic logic sel_kplus(input int unsigned blk, input int unsigned c_minus);
    return blk >= c_minus;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cb_seq_ctrl_if.sv
`default_nettype none
//==========================================================================
// cb_seq_ctrl_if : segmentation descriptor handshake bus
// Rev 1.0
//==========================================================================
interface cb_seq_ctrl_if #(
  parameter int KW = cb_seq_ctrl_pkg::KW_DEF,
  parameter int CW = cb_seq_ctrl_pkg::CW_DEF,
  parameter int FW = cb_seq_ctrl_pkg::FW_DEF
);
  logic          desc_valid;
  logic          desc_ready;
  logic [CW-1:0] c_num;
  logic [CW-1:0] c_minus;
  logic [KW-1:0] k_plus;
  logic [KW-1:0] k_minus;
  logic [FW-1:0] f_num;

  modport master (
    output desc_valid, c_num, c_minus, k_plus, k_minus, f_num,
    input  desc_ready
  );

  modport slave (
    input  desc_valid, c_num, c_minus, k_plus, k_minus, f_num,
    output desc_ready
  );
endinterface
`default_nettype wire

// File: rtl/cb_len_calc.sv
`default_nettype none
//==========================================================================
// cb_len_calc : per-block filler / data lengths and K+/K- select
// Rev 1.0
//==========================================================================
module cb_len_calc
  import cb_seq_ctrl_pkg::*;
#(
  parameter int KW = KW_DEF,
  parameter int CW = CW_DEF,
  parameter int FW = FW_DEF
) (
  input  logic [CW-1:0] blk,
  input  logic [CW-1:0] c_num,
  input  logic [CW-1:0] c_minus,
  input  logic [KW-1:0] k_plus,
  input  logic [KW-1:0] k_minus,
  input  logic [FW-1:0] f_num,
  output logic          kplus_sel,
  output logic          multi,
  output logic [KW-1:0] fill_len,
  output logic [KW-1:0] data_len
);
  logic [KW-1:0] w_k_len;
  logic [KW-1:0] w_crc_len;

  always_comb begin
    kplus_sel = sel_kplus(32'(blk), 32'(c_minus));
    multi     = (c_num > CW'(1));
    w_k_len   = kplus_sel ? k_plus : k_minus;
    fill_len  = (blk == '0) ? KW'(f_num) : '0;
    w_crc_len = multi ? KW'(CRC_LEN) : '0;
    data_len  = w_k_len - fill_len - w_crc_len;
  end
endmodule
`default_nettype wire

// File: rtl/cb_seq_ctrl.sv
`default_nettype none
//==========================================================================
// cb_seq_ctrl : walks C code blocks emitting filler, data and CRC framing
// Rev 1.0
//==========================================================================
module cb_seq_ctrl
  import cb_seq_ctrl_pkg::*;
#(
  parameter int KW = KW_DEF,
  parameter int CW = CW_DEF,
  parameter int FW = FW_DEF
) (
  input  logic         clk,
  input  logic         reset,
  cb_seq_ctrl_if.slave desc,
  input  logic         fifo_empty,
  output logic         fifo_rd,
  output logic         mux_fill,
  output logic         mux_crc,
  output logic         crc_init,
  output logic         crc_en,
  output logic         crc_nshift,
  output logic         bit_valid,
  output logic         start,
  output logic         stop,
  output logic         filling,
  output logic         crc,
  output logic         block_size,
  output logic         busy,
  output logic         done,
  output logic         size_err
);
  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_c, r_cm, r_blk;
  logic [KW-1:0] r_kp, r_km, r_cnt;
  logic [FW-1:0] r_f;
  logic          r_first;

  logic          w_kplus, w_multi;
  logic [KW-1:0] w_fill_len, w_data_len, w_thr;
  logic          w_size_bad, w_last_blk, w_fill_last, w_data_last, w_crc_last;
  state_t        w_eob_state, w_after_data, w_after_fill;

  cb_len_calc #(.KW(KW), .CW(CW), .FW(FW)) u_len_calc (
    .blk       (r_blk),
    .c_num     (r_c),
    .c_minus   (r_cm),
    .k_plus    (r_kp),
    .k_minus   (r_km),
    .f_num     (r_f),
    .kplus_sel (w_kplus),
    .multi     (w_multi),
    .fill_len  (w_fill_len),
    .data_len  (w_data_len)
  );

  always_comb begin
    w_thr        = KW'(CRC_LEN) + KW'(r_f);
    w_size_bad   = (r_c > CW'(1)) && (((r_cm != '0) && (r_km <= w_thr)) || (r_kp <= w_thr));
    w_last_blk   = ({1'b0, r_blk} + {{CW{1'b0}}, 1'b1}) >= {1'b0, r_c};
    w_fill_last  = (r_cnt == w_fill_len - KW'(1));
    w_data_last  = (r_cnt == w_data_len - KW'(1));
    w_crc_last   = (r_cnt == KW'(CRC_LEN - 1));
    w_eob_state  = w_last_blk ? S_FIN : S_BSTART;
    w_after_data = w_multi ? S_CRCO : w_eob_state;
    w_after_fill = (w_data_len == '0) ? w_after_data : S_DATA;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (desc.desc_valid) w_state_nxt = S_LOAD;
      S_LOAD: begin
        if (r_c == '0)      w_state_nxt = S_FIN;
        else if (w_size_bad) w_state_nxt = S_IDLE;
        else                w_state_nxt = S_BSTART;
      end
      S_BSTART: w_state_nxt = (w_fill_len != '0) ? S_FILL : w_after_fill;
      S_FILL:   if (w_fill_last) w_state_nxt = w_after_fill;
      S_DATA:   if (!fifo_empty && w_data_last) w_state_nxt = w_after_data;
      S_CRCO:   if (w_crc_last) w_state_nxt = w_eob_state;
      S_FIN:    w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    desc.desc_ready = 1'b0;
    fifo_rd    = 1'b0;
    mux_fill   = 1'b0;
    mux_crc    = 1'b0;
    crc_init   = 1'b0;
    crc_en     = 1'b0;
    crc_nshift = 1'b1;
    bit_valid  = 1'b0;
    stop       = 1'b0;
    filling    = 1'b0;
    crc        = 1'b0;
    block_size = 1'b0;
    done       = 1'b0;
    size_err   = 1'b0;
    busy       = (r_state != S_IDLE);
    case (r_state)
      // Gated by reset so the bus never sees ready while held in reset.
      S_IDLE:   desc.desc_ready = reset;
      S_LOAD:   size_err = (r_c != '0) && w_size_bad;
      S_BSTART: begin
        crc_init   = 1'b1;
        block_size = w_kplus;
      end
      S_FILL: begin
        bit_valid  = 1'b1;
        filling    = 1'b1;
        crc_en     = 1'b1;
        block_size = w_kplus;
        stop       = w_fill_last && (w_data_len == '0) && !w_multi;
      end
      S_DATA: begin
        mux_fill   = 1'b1;
        fifo_rd    = !fifo_empty;
        crc_en     = !fifo_empty;
        bit_valid  = !fifo_empty;
        block_size = w_kplus;
        stop       = !fifo_empty && w_data_last && !w_multi;
      end
      S_CRCO: begin
        mux_crc    = 1'b1;
        crc_nshift = 1'b0;
        crc        = 1'b1;
        bit_valid  = 1'b1;
        block_size = w_kplus;
        stop       = w_crc_last;
      end
      S_FIN:    done = 1'b1;
      default:  ;
    endcase
    start = bit_valid && r_first;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_c     <= '0;
      r_cm    <= '0;
      r_kp    <= '0;
      r_km    <= '0;
      r_f     <= '0;
      r_blk   <= '0;
      r_cnt   <= '0;
      r_first <= 1'b0;
    end else begin
      if (r_state == S_IDLE && desc.desc_valid) begin
        r_c  <= desc.c_num;
        r_cm <= desc.c_minus;
        r_kp <= desc.k_plus;
        r_km <= desc.k_minus;
        r_f  <= desc.f_num;
      end
      if (r_state == S_LOAD)
        r_blk <= '0;
      else if (w_state_nxt == S_BSTART)
        r_blk <= r_blk + CW'(1);
      // Each phase restarts the bit count; stalled DATA cycles hold it.
      if (w_state_nxt != r_state)
        r_cnt <= '0;
      else if (bit_valid)
        r_cnt <= r_cnt + KW'(1);
      if (r_state == S_BSTART)
        r_first <= 1'b1;
      else if (bit_valid)
        r_first <= 1'b0;
    end
  end
endmodule
`default_nettype wire
